sigmoid_grad_seq: RTL and testbench
===================================

Name: sigmoid_grad_seq

Overview:
- Backward-direction companion to the forward sigmoid PWL unit.
- Takes a stored forward output y = sigmoid(x) and an upstream gradient g, and returns dx = g * y * (1 - y) for backprop.
- Uses one shared sequential shift-add multiplier under an FSM, with valid/ready handshakes on both sides.
- Operates on the same Q7.9 fixed-point format as the forward datapath.

Parameters:
- WIDTH, 16, data word width; also the number of shift-add steps per multiply.
- FRAC, 9, fractional bits; 1.0 = 1<<FRAC (0x200).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  y/g valid.
- in_ready  out  1  block can accept; high only in IDLE.
- y  in  WIDTH  forward sigmoid output, unsigned Q7.9.
- g  in  WIDTH  upstream gradient, signed two's-complement Q7.9.
- out_valid  out  1  dx valid; high only in DONE.
- out_ready  in  1  downstream accepts dx.
- dx  out  WIDTH  result, signed Q7.9.

Behaviour:
- Reset: while rst=1 at an edge, state goes to IDLE and all internal registers clear. Outputs: in_ready=1 (after reset), out_valid=0, dx=0.
- Reset mid-operation aborts the in-flight item with no output produced.
- States: IDLE, MUL1, MUL2, SAT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, capture yc = min(y, 0x200) (unsigned compare) and om = 0x200 - yc.
  - Capture sg = g[WIDTH-1] and mg = |g| as WIDTH-bit unsigned; g=0x8000 gives mg=0x8000.
  - Clear the accumulator and step counter; go to MUL1.
- MUL1:
  - One step per cycle, WIDTH cycles, computing P1 = yc*om (2*WIDTH-bit accumulator).
  - Step i adds (om<<i) when bit i of yc is set.
  - After step WIDTH-1: p = P1>>FRAC (truncate, max 0x80), reload counter, go to MUL2.
- MUL2:
  - WIDTH cycles, same scheme, computing P2 = mg*p.
  - After the last step go to SAT.
- SAT (1 cycle):
  - m = P2>>FRAC (magnitude truncation, i.e. rounds toward zero for both signs).
  - If sg=0: dx = min(m, 0x7FFF).
  - If sg=1: dx = -min(m, 0x8000).
  - Go to DONE.
  - Saturation is unreachable at default params but is required.
- DONE:
  - out_valid=1; dx held stable until handshake.
  - On out_ready at an edge, go to IDLE; out_valid drops next cycle.
  - dx holds its last value in IDLE; only out_valid qualifies it.
- Latency: out_valid rises after the (2*WIDTH+2)-th rising edge counting the accepting edge as 1 (34 at WIDTH=16).
- Throughput: 1 item per 2*WIDTH+3 cycles with out_ready held high.
- in_valid is ignored outside IDLE. y/g may change freely after acceptance.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- y > 0x200 (illegal for the forward unit) is clamped, giving dx=0. y=0 gives dx=0.

Test Plan:
1. Reset then y=0x100, g=0x200 -> dx=0x0080, out_valid rising exactly 34 edges after accept; in_ready=0 throughout.
2. y=0x080, g=0x400 -> dx=0x00C0. y=0x100, g=0x8000 -> dx=0xE000.
3. Truncation toward zero:
   - y=0x101, g=0xFFF5 -> dx=0xFFFE (not 0xFFFD).
   - y=0x101, g=0xFC00 -> dx=0xFF02.
4. Boundaries: y=0x000, g=0x7FFF -> dx=0x0000. y=0x250, g=0x200 -> dx=0x0000 (clamp). y=0x200 -> dx=0x0000.
5. Backpressure:
   - Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, dx stable, in_ready=0, and in_valid pulses are ignored.
   - Release -> IDLE next cycle; back-to-back items are spaced 35 cycles.
6. Assert rst at step 20 of an operation -> next cycle out_valid=0, dx=0, in_ready=1; that item never appears; the following item computes correctly.

Source files
------------

// File: rtl/sigmoid_grad_seq_if.sv
// -----------------------------------------------------------------------------
// sigmoid_grad_seq_if
//   Handshake bundle for the sigmoid backward-gradient unit.
//
//   Input side (producer -> unit):
//     in_valid  : y/g pair is valid
//     in_ready  : unit can accept a pair
//     y         : forward sigmoid output, unsigned Q7.9
//     g         : upstream gradient, signed Q7.9
//   Output side (unit -> consumer):
//     out_valid : dx is valid
//     out_ready : consumer accepts dx
//     dx        : gradient result, signed Q7.9
//
//   master : the side that supplies y/g and consumes dx
//   slave  : the gradient unit itself
// -----------------------------------------------------------------------------
interface sigmoid_grad_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] g;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dx;

   modport master (
      output in_valid,
      input  in_ready,
      output y,
      output g,
      input  out_valid,
      output out_ready,
      input  dx
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  y,
      input  g,
      output out_valid,
      input  out_ready,
      output dx
   );
endinterface

// File: rtl/sigmoid_grad_seq.sv
// -----------------------------------------------------------------------------
// sigmoid_grad_seq
//   Backward companion of the forward sigmoid PWL unit. Given a stored forward
//   output y = sigmoid(x) and an upstream gradient g it returns
//       dx = g * y * (1 - y)
//   in Q7.9 fixed point, using a single sequential shift-add multiplier that
//   is reused for both products.
//
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : synchronous, active-high reset (aborts any in-flight item)
//     bus : sigmoid_grad_seq_if.slave
//             in_valid/in_ready/y/g    - operand handshake (accept in IDLE)
//             out_valid/out_ready/dx   - result handshake (present in DONE)
//
//   Sequence: IDLE -> MUL1 (WIDTH cycles, y*(1-y)) -> MUL2 (WIDTH cycles,
//   |g|*p) -> SAT (1 cycle) -> DONE. Sign is handled as sign/magnitude so
//   truncation rounds toward zero for negative gradients as well.
// -----------------------------------------------------------------------------
module sigmoid_grad_seq #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   sigmoid_grad_seq_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL1 = 3'd1;
   localparam logic [2:0] S_MUL2 = 3'd2;
   localparam logic [2:0] S_SAT  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // 1.0 in Q7.9 and the LSB constant used for two's-complement negation.
   localparam logic [WIDTH-1:0]   ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [WIDTH-1:0]   LSB     = {{(WIDTH-1){1'b0}}, 1'b1};
   // Largest positive magnitude and largest negative magnitude of the output.
   localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   // --------------------------------------------------------------------------
   // Saturating sign application: clip the magnitude to the representable
   // range for the requested sign, then negate if needed.
   // --------------------------------------------------------------------------
   function automatic logic signed [WIDTH-1:0] sat_dx(
      input logic [2*WIDTH-1:0] mag,
      input logic               neg
   );
      logic [2*WIDTH-1:0] lim;
      logic [WIDTH-1:0]   lo;
      if (neg) begin
         lim    = (mag > NEG_MAX) ? NEG_MAX : mag;
         lo     = lim[WIDTH-1:0];
         sat_dx = $signed(~lo + LSB);
      end else begin
         lim    = (mag > POS_MAX) ? POS_MAX : mag;
         lo     = lim[WIDTH-1:0];
         sat_dx = $signed(lo);
      end
   endfunction

   // Magnitude of a two's-complement word as unsigned; the most negative
   // value maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
      abs_mag = v[WIDTH-1] ? (~v + LSB) : v;
   endfunction

   logic [2:0]              state;
   logic [CW-1:0]           cnt;
   logic [WIDTH-1:0]        yc;
   logic [WIDTH-1:0]        om;
   logic                    sg;
   logic [WIDTH-1:0]        mg;
   logic [WIDTH-1:0]        p;
   logic [2*WIDTH-1:0]      acc;
   logic signed [WIDTH-1:0] dx_r;

   logic [WIDTH-1:0]        y_clamp;
   logic [WIDTH-1:0]        mcand;
   logic                    mbit;
   logic [2*WIDTH-1:0]      addend;
   logic [2*WIDTH-1:0]      acc_next;
   logic                    last_step;

   // Inputs above 1.0 cannot come from the forward unit; clamp them so the
   // (1 - y) term never goes negative.
   assign y_clamp = (bus.y > ONE) ? ONE : bus.y;

   // Shared shift-add datapath. MUL1 walks the bits of yc against om,
   // MUL2 walks the bits of |g| against p.
   always_comb begin
      mcand    = (state == S_MUL2) ? p : om;
      mbit     = (state == S_MUL2) ? mg[cnt] : yc[cnt];
      addend   = mbit ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
      acc_next = acc + addend;
   end

   assign last_step = (cnt == CW'(WIDTH - 1));

   // --------------------------------------------------------------------------
   // Control FSM and operand/result registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         yc    <= '0;
         om    <= '0;
         sg    <= 1'b0;
         mg    <= '0;
         p     <= '0;
         acc   <= '0;
         dx_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  yc    <= y_clamp;
                  om    <= ONE - y_clamp;
                  sg    <= bus.g[WIDTH-1];
                  mg    <= abs_mag(bus.g);
                  acc   <= '0;
                  cnt   <= '0;
                  state <= S_MUL1;
               end
            end

            S_MUL1: begin
               if (last_step) begin
                  // y*(1-y) never exceeds 0.25, so p fits comfortably.
                  p     <= acc_next[FRAC +: WIDTH];
                  acc   <= '0;
                  cnt   <= '0;
                  state <= S_MUL2;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + CW'(1);
               end
            end

            S_MUL2: begin
               acc <= acc_next;
               if (last_step) begin
                  state <= S_SAT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_SAT: begin
               dx_r  <= sat_dx(acc >> FRAC, sg);
               state <= S_DONE;
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs depend on state only, so there is no combinational
   // path from in_valid or out_ready.
   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.dx        = $unsigned(dx_r);

endmodule

// File: tb/tb_sigmoid_grad_seq.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_grad_seq
//   Directed bench for sigmoid_grad_seq with hand-computed expected values.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sigmoid_grad_seq;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   sigmoid_grad_seq_if #(.WIDTH(16)) bus ();

   sigmoid_grad_seq #(.WIDTH(16), .FRAC(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one pair and return right after the accepting edge.
   task automatic start_item(input logic [15:0] yv, input logic [15:0] gv);
      int w;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      check("start_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.y        = yv;
      bus.g        = gv;
      tick();
      bus.in_valid = 1'b0;
      bus.y        = 16'($urandom);
      bus.g        = 16'($urandom);
   endtask

   // Count edges from the accepting edge (edge 1) until out_valid shows.
   task automatic wait_done(output int lat, output logic rdy_low);
      lat     = 1;
      rdy_low = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
         tick();
         lat++;
      end
   endtask

   task automatic run_item(input string tag, input logic [15:0] yv,
                           input logic [15:0] gv, input logic [15:0] exp_dx);
      int   lat;
      logic rdy_low;
      start_item(yv, gv);
      wait_done(lat, rdy_low);
      check({tag, "_lat"}, lat, 32'd34);
      check({tag, "_busy"}, {31'd0, rdy_low}, 32'd1);
      check({tag, "_dx"}, {16'd0, bus.dx}, {16'd0, exp_dx});
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_ovdrop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_dxhold"}, {16'd0, bus.dx}, {16'd0, exp_dx});
   endtask

   initial begin
      int   lat;
      logic rdy_low;
      int   acc_edge[$];
      int   ov_seen;
      logic ov_ok;
      logic [15:0] dx_bb;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.y         = '0;
      bus.g         = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_dx", {16'd0, bus.dx}, 32'd0);

      // Main function
      run_item("half",    16'h0100, 16'h0200, 16'h0080);
      run_item("quarter", 16'h0080, 16'h0400, 16'h00C0);
      run_item("gmin",    16'h0100, 16'h8000, 16'hE000);
      // Truncation toward zero on negative gradients
      run_item("trunc1",  16'h0101, 16'hFFF5, 16'hFFFE);
      run_item("trunc2",  16'h0101, 16'hFC00, 16'hFF02);
      // Boundaries
      run_item("y0",      16'h0000, 16'h7FFF, 16'h0000);
      run_item("clamp",   16'h0250, 16'h0200, 16'h0000);
      run_item("y1",      16'h0200, 16'h0200, 16'h0000);

      // Backpressure: hold DONE for 10 cycles while in_valid pulses
      start_item(16'h0101, 16'hFC00);
      wait_done(lat, rdy_low);
      check("bp_lat", lat, 32'd34);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.y        = 16'h0100;
         bus.g        = 16'h0200;
         tick();
         check("bp_ov", {31'd0, bus.out_valid}, 32'd1);
         check("bp_dx", {16'd0, bus.dx}, 32'h0000FF02);
         check("bp_inrdy", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_release_ov", {31'd0, bus.out_valid}, 32'd0);
      check("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);

      // Back-to-back items with both sides always willing
      bus.in_valid  = 1'b1;
      bus.y         = 16'h0100;
      bus.g         = 16'h0200;
      bus.out_ready = 1'b1;
      ov_seen       = 0;
      ov_ok         = 1'b1;
      for (int e = 1; e <= 80; e++) begin
         if (bus.in_ready && bus.in_valid) acc_edge.push_back(e);
         tick();
         if (bus.out_valid) begin
            ov_seen++;
            if (bus.dx !== 16'h0080) ov_ok = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b_count", (acc_edge.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
      if (acc_edge.size() >= 2)
         check("b2b_spacing", acc_edge[1] - acc_edge[0], 32'd35);
      check("b2b_results", ov_seen, 32'd2);
      check("b2b_dx", {31'd0, ov_ok}, 32'd1);
      // Drain whatever is in flight so the next test starts in IDLE.
      repeat (40) begin
         bus.out_ready = 1'b1;
         tick();
      end
      bus.out_ready = 1'b0;
      dx_bb = bus.dx;
      check("pre_abort_dx", {16'd0, dx_bb}, 32'h00000080);

      // Reset mid-operation
      start_item(16'h0100, 16'h0400);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ov", {31'd0, bus.out_valid}, 32'd0);
      check("abort_dx", {16'd0, bus.dx}, 32'd0);
      check("abort_rdy", {31'd0, bus.in_ready}, 32'd1);
      ov_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) ov_seen++;
      end
      check("abort_no_out", ov_seen, 32'd0);
      run_item("after_abort", 16'h0080, 16'h0400, 16'h00C0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
